reset_sequencer: RTL and testbench

Sits directly downstream of the bench clock/reset generator and upstream of every design domain. It synchronizes release of the raw asynchronous active-low reset and releases per-domain resets in a fixed staggered order. Once all domains are out of reset, it watches the run for a halt request, a global cycle timeout, or a heartbeat stall, and latches the outcome. It gives the pipeline one deterministic reset-release point and one pass/fail verdict.

---
 rtl/reset_seq_pkg.sv | 27 ++
 rtl/reset_sync.sv | 25 ++
 rtl/reset_sequencer.sv | 147 ++++++++++++++
 tb/tb_reset_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM state encoding,
// parameter defaults and counter width.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    RESET,
    RELEASE,
    RUN,
    DONE,
    TO,
    STALL
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_NUM_DOMAINS = 3;
  localparam int unsigned DEF_STAGE_GAP   = 4;
  localparam int unsigned DEF_TIMEOUT     = 100000;
  localparam int unsigned DEF_HB_LIMIT    = 1000;

  localparam int unsigned CNT_W = 32;

  // Index width that stays legal when only one domain exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after SYNC_STAGES
// clock edges so downstream logic sees a clean release.
module reset_sync
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_rst_sync_n
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign o_rst_sync_n = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staggered per-domain reset release followed by run monitoring that latches
// a single halt / timeout / heartbeat-stall verdict.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int unsigned STAGE_GAP   = DEF_STAGE_GAP,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned HB_LIMIT    = DEF_HB_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   heartbeat_i,
  input  logic                   halt_i,
  output logic [NUM_DOMAINS-1:0] dom_rst_n_o,
  output logic                   ready_o,
  output logic [CNT_W-1:0]       cycle_cnt_o,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic                   stall_o
);

  localparam int unsigned        IDX_W    = idx_width(NUM_DOMAINS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   HB_LAST  = CNT_W'(HB_LIMIT - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (NUM_DOMAINS < 1) begin : g_bad_dom
    $error("reset_sequencer: NUM_DOMAINS must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $error("reset_sequencer: STAGE_GAP must be >= 1");
  end

  state_e                 r_state;
  logic [NUM_DOMAINS-1:0] r_dom_rst_n;
  logic [IDX_W-1:0]       r_dom_idx;
  logic [CNT_W-1:0]       r_gap_cnt;
  logic [CNT_W-1:0]       r_hb_cnt;
  logic [CNT_W-1:0]       r_cycle_cnt;
  logic                   r_ready;
  logic                   r_done;
  logic                   r_timeout;
  logic                   r_stall;

  logic                   w_rst_sync_n;
  logic [NUM_DOMAINS-1:0] w_next_dom;

  reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_rst_sync_n (w_rst_sync_n)
  );

  // Domain mask with the next-in-order bit released; earlier bits stay set.
  always_comb begin
    w_next_dom = r_dom_rst_n;
    for (int k = 0; k < int'(NUM_DOMAINS); k++) begin
      if (k == int'(r_dom_idx) + 1) begin
        w_next_dom[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESET;
      r_dom_rst_n <= '0;
      r_dom_idx   <= '0;
      r_gap_cnt   <= '0;
      r_hb_cnt    <= '0;
      r_cycle_cnt <= '0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      case (r_state)
        RESET: begin
          if (w_rst_sync_n) begin
            r_state        <= RELEASE;
            r_dom_rst_n[0] <= 1'b1;
            r_dom_idx      <= '0;
            r_gap_cnt      <= '0;
          end
        end

        RELEASE: begin
          if (r_dom_idx == LAST_IDX) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt   <= '0;
            r_dom_idx   <= r_dom_idx + IDX_W'(1);
            r_dom_rst_n <= w_next_dom;
          end else begin
            r_gap_cnt <= r_gap_cnt + CNT_W'(1);
          end
        end

        RUN: begin
          // Halt outranks timeout; a same-cycle heartbeat cancels a stall.
          if (halt_i) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_ready <= 1'b0;
          end else if (r_cycle_cnt == TO_LAST) begin
            r_state   <= TO;
            r_timeout <= 1'b1;
            r_ready   <= 1'b0;
          end else if (!heartbeat_i && (r_hb_cnt == HB_LAST)) begin
            r_state <= STALL;
            r_stall <= 1'b1;
            r_ready <= 1'b0;
          end else begin
            if (r_cycle_cnt != '1) begin
              r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (heartbeat_i) begin
              r_hb_cnt <= '0;
            end else if (r_hb_cnt != '1) begin
              r_hb_cnt <= r_hb_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign dom_rst_n_o = r_dom_rst_n;
  assign ready_o     = r_ready;
  assign cycle_cnt_o = r_cycle_cnt;
  assign done_o      = r_done;
  assign timeout_o   = r_timeout;
  assign stall_o     = r_stall;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three instances (defaults, short timeout,
// short heartbeat limit) checked against a release table and scenarios.
module tb_reset_sequencer;

  logic        clk;
  logic        rst_n;
  logic        hb    [3];
  logic        halt  [3];
  logic [2:0]  dom   [3];
  logic        ready [3];
  logic [31:0] cnt   [3];
  logic        done  [3];
  logic        tmo   [3];
  logic        stall [3];

  typedef struct {
    logic [2:0]  dom;
    logic        ready;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [2:0]  dom;
    logic        ready;
    logic [31:0] cnt;
    logic        cnt_chk;
    logic        done;
    logic        to;
    logic        stall;
  } exp_t;

  vec_t rel_tbl [13];
  exp_t exp_q [$];
  int   n_tests;
  int   n_fail;

  reset_sequencer u_dut_def (
    .clk(clk), .rst_n(rst_n), .heartbeat_i(hb[0]), .halt_i(halt[0]),
    .dom_rst_n_o(dom[0]), .ready_o(ready[0]), .cycle_cnt_o(cnt[0]),
    .done_o(done[0]), .timeout_o(tmo[0]), .stall_o(stall[0])
  );

  reset_sequencer #(.TIMEOUT(20)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .heartbeat_i(hb[1]), .halt_i(halt[1]),
    .dom_rst_n_o(dom[1]), .ready_o(ready[1]), .cycle_cnt_o(cnt[1]),
    .done_o(done[1]), .timeout_o(tmo[1]), .stall_o(stall[1])
  );

  reset_sequencer #(.HB_LIMIT(8)) u_dut_hb (
    .clk(clk), .rst_n(rst_n), .heartbeat_i(hb[2]), .halt_i(halt[2]),
    .dom_rst_n_o(dom[2]), .ready_o(ready[2]), .cycle_cnt_o(cnt[2]),
    .done_o(done[2]), .timeout_o(tmo[2]), .stall_o(stall[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string nm, input logic [2:0] d, input logic r,
                      input logic [31:0] c, input logic cc, input logic dn,
                      input logic t, input logic s);
    exp_t e;
    e.name = nm; e.dom = d; e.ready = r; e.cnt = c; e.cnt_chk = cc;
    e.done = dn; e.to = t; e.stall = s;
    exp_q.push_back(e);
  endtask

  task automatic check(input int sel);
    exp_t e;
    e = exp_q.pop_front();
    n_tests++;
    if (dom[sel] !== e.dom || ready[sel] !== e.ready ||
        (e.cnt_chk && cnt[sel] !== e.cnt) || done[sel] !== e.done ||
        tmo[sel] !== e.to || stall[sel] !== e.stall) begin
      n_fail++;
      $display("FAIL %s dut%0d: got dom=%b rdy=%b cnt=%0d done=%b to=%b stall=%b, required dom=%b rdy=%b cnt=%0d done=%b to=%b stall=%b",
               e.name, sel, dom[sel], ready[sel], cnt[sel], done[sel], tmo[sel], stall[sel],
               e.dom, e.ready, e.cnt, e.done, e.to, e.stall);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int sel, input logic [31:0] target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      edge_sample();
      if (cnt[sel] == target) hit = 1'b1;
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_cnt dut%0d: got cnt=%0d, required %0d within budget", sel, cnt[sel], target);
    end
  endtask

  // Asynchronous clear is checked mid-cycle; release lands on a negedge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hb[k] = 1'b0;
      halt[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      push("reset_state", 3'b000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      check(k);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0 && (i % 10) == 9) hb[0] = ~hb[0];
      push($sformatf("release_e%0d", i + 1), rel_tbl[i].dom, rel_tbl[i].ready,
           rel_tbl[i].cnt, 1'b1, 1'b0, 1'b0, 1'b0);
      edge_sample();
      check(sel);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hb[k] = 1'b0;
      halt[k] = 1'b0;
    end

    rel_tbl[0]  = '{dom: 3'b000, ready: 1'b0, cnt: 32'd0};
    rel_tbl[1]  = '{dom: 3'b000, ready: 1'b0, cnt: 32'd0};
    rel_tbl[2]  = '{dom: 3'b001, ready: 1'b0, cnt: 32'd0};
    rel_tbl[3]  = '{dom: 3'b001, ready: 1'b0, cnt: 32'd0};
    rel_tbl[4]  = '{dom: 3'b001, ready: 1'b0, cnt: 32'd0};
    rel_tbl[5]  = '{dom: 3'b001, ready: 1'b0, cnt: 32'd0};
    rel_tbl[6]  = '{dom: 3'b011, ready: 1'b0, cnt: 32'd0};
    rel_tbl[7]  = '{dom: 3'b011, ready: 1'b0, cnt: 32'd0};
    rel_tbl[8]  = '{dom: 3'b011, ready: 1'b0, cnt: 32'd0};
    rel_tbl[9]  = '{dom: 3'b011, ready: 1'b0, cnt: 32'd0};
    rel_tbl[10] = '{dom: 3'b111, ready: 1'b0, cnt: 32'd0};
    rel_tbl[11] = '{dom: 3'b111, ready: 1'b1, cnt: 32'd0};
    rel_tbl[12] = '{dom: 3'b111, ready: 1'b1, cnt: 32'd1};

    // Clean release
    do_reset();
    run_table(0, 13);

    // Halt at count 50, then heartbeat activity must not disturb the verdict
    wait_cnt(0, 32'd50);
    halt[0] = 1'b1;
    push("halt_done", 3'b111, 1'b0, 32'd50, 1'b1, 1'b1, 1'b0, 1'b0);
    edge_sample();
    check(0);
    halt[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hb[0] = ~hb[0];
      push("halt_hold", 3'b111, 1'b0, 32'd50, 1'b1, 1'b1, 1'b0, 1'b0);
      edge_sample();
      check(0);
    end

    // Timeout with heartbeat every cycle
    do_reset();
    hb[1] = 1'b1;
    run_table(1, 13);
    wait_cnt(1, 32'd19);
    push("pre_timeout", 3'b111, 1'b1, 32'd19, 1'b1, 1'b0, 1'b0, 1'b0);
    check(1);
    push("timeout", 3'b111, 1'b0, 32'd19, 1'b1, 1'b0, 1'b1, 1'b0);
    edge_sample();
    check(1);
    for (int i = 0; i < 3; i++) begin
      push("timeout_hold", 3'b111, 1'b0, 32'd19, 1'b1, 1'b0, 1'b1, 1'b0);
      edge_sample();
      check(1);
    end

    // Halt on the timeout threshold cycle gives DONE only
    do_reset();
    hb[1] = 1'b1;
    run_table(1, 13);
    wait_cnt(1, 32'd19);
    halt[1] = 1'b1;
    push("halt_vs_timeout", 3'b111, 1'b0, 32'd19, 1'b1, 1'b1, 1'b0, 1'b0);
    edge_sample();
    check(1);
    halt[1] = 1'b0;
    push("halt_vs_timeout_hold", 3'b111, 1'b0, 32'd19, 1'b1, 1'b1, 1'b0, 1'b0);
    edge_sample();
    check(1);

    // Stall: one heartbeat at RUN cycle 2, then silence
    do_reset();
    run_table(2, 13);
    wait_cnt(2, 32'd2);
    hb[2] = 1'b1;
    edge_sample();
    hb[2] = 1'b0;
    wait_cnt(2, 32'd10);
    push("pre_stall", 3'b111, 1'b1, 32'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    check(2);
    push("stall", 3'b111, 1'b0, 32'd10, 1'b1, 1'b0, 1'b0, 1'b1);
    edge_sample();
    check(2);

    // Heartbeat on the threshold cycle wins, stall comes 8 cycles later
    do_reset();
    run_table(2, 13);
    wait_cnt(2, 32'd2);
    hb[2] = 1'b1;
    edge_sample();
    hb[2] = 1'b0;
    wait_cnt(2, 32'd10);
    hb[2] = 1'b1;
    push("hb_beats_stall", 3'b111, 1'b1, 32'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    edge_sample();
    check(2);
    hb[2] = 1'b0;
    wait_cnt(2, 32'd18);
    push("pre_stall2", 3'b111, 1'b1, 32'd18, 1'b1, 1'b0, 1'b0, 1'b0);
    check(2);
    push("stall2", 3'b111, 1'b0, 32'd18, 1'b1, 1'b0, 1'b0, 1'b1);
    edge_sample();
    check(2);

    // Reset mid-RELEASE drops domains without a clock, then full re-release
    do_reset();
    run_table(0, 8);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_drop", 3'b000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check(0);
    do_reset();
    run_table(0, 13);

    // Half-cycle high pulse while held in reset releases nothing
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push("high_glitch", 3'b000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      edge_sample();
      check(0);
    end

    // Short low glitch while the chain fills restarts the whole sequence
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    run_table(0, 13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
